// File: rtl/clk_rst_seq_pkg.sv
// Shared types and helpers for the clock-enable / reset sequencer.
package clk_rst_seq_pkg;

  // Sequencer states: wait for lock, qualify it, stagger resets, run.
  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    STABLE  = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_e;

  // Width of a counter that must hold values 0 .. max_count-1 (at least 1 bit).
  function automatic int unsigned cnt_w(input int unsigned max_count);
    return (max_count <= 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// One channel of the clock-enable divider: shadow divide register,
// free-running down-counter and reset-masked enable output.
module clk_en_div
  import clk_rst_seq_pkg::*;
#(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DIV_DEFAULT = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_load,
  input  logic             i_en_mask,
  output logic             o_clk_en
);

  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;

  // Next-state: a load re-phases the counter to zero so every channel pulses together next cycle.
  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    en_d     = (cnt_q == '0) && i_en_mask;
    if (i_load) begin
      shadow_d = i_div;
    end
    if (i_load) begin
      cnt_d = '0;
    end else if (cnt_q == '0) begin
      cnt_d = shadow_q;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Divider registers; the counter keeps running while the channel is held in reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow_q <= DIV_W'(DIV_DEFAULT);
      cnt_q    <= '0;
      en_q     <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
    end
  end

  assign o_clk_en = en_q;

endmodule

// File: rtl/clk_rst_seq.sv
// Clock-enable and reset sequencer for the MMCM generated clock domain.
// Optional build macro CLK_RST_SEQ_LOSS_CNT_EN adds a saturating lock-loss counter output.
module clk_rst_seq
  import clk_rst_seq_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DIV_DEFAULT = 0,
  parameter int unsigned LOCK_CNT    = 256,
  parameter int unsigned RST_STAGGER = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_locked,
  input  logic [NUM_CH*DIV_W-1:0] i_div,
  input  logic                    i_div_load,
  input  logic                    i_clr_lost,
  output logic [NUM_CH-1:0]       o_rst_n,
  output logic [NUM_CH-1:0]       o_clk_en,
  output logic                    o_ready,
  output logic                    o_lock_lost
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0]              o_loss_cnt
`endif
);

  localparam int unsigned LOCK_W = cnt_w(LOCK_CNT);
  localparam int unsigned STG_W  = cnt_w(RST_STAGGER * NUM_CH);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk;

  state_e                 state_q, state_d;
  logic [LOCK_W-1:0]      cnt_q, cnt_d;
  logic [STG_W-1:0]       sc_q, sc_d;
  logic [NUM_CH-1:0]      rst_q, rst_d;
  logic                   ready_q, ready_d;
  logic                   lost_q, lost_d;
  logic                   loss;

  // Lock synchroniser: i_locked is asynchronous to i_clk.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_locked};
    end
  end

  assign lk = sync_q[SYNC_STAGES-1];

  // Next-state: lock qualification, staggered release and lock-loss abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sc_d    = sc_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    loss    = 1'b0;
    unique case (state_q)
      WAIT: begin
        cnt_d   = '0;
        rst_d   = '0;
        ready_d = 1'b0;
        if (lk) begin
          state_d = STABLE;
        end
      end
      STABLE: begin
        if (!lk) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_W'(LOCK_CNT - 1)) begin
          state_d = RELEASE;
          sc_d    = '0;
          rst_d   = NUM_CH'(1);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!lk) begin
          loss = 1'b1;
        end else if (rst_q[NUM_CH-1]) begin
          state_d = RUN;
          ready_d = 1'b1;
        end else begin
          sc_d = sc_q + 1'b1;
          for (int unsigned k = 1; k < NUM_CH; k++) begin
            rst_d[k] = rst_q[k] | (sc_d == STG_W'(k * RST_STAGGER));
          end
        end
      end
      RUN: begin
        if (!lk) begin
          loss = 1'b1;
        end
      end
    endcase
    if (loss) begin
      state_d = WAIT;
      cnt_d   = '0;
      rst_d   = '0;
      ready_d = 1'b0;
    end
    // A loss in the same cycle as a clear request keeps the flag set.
    lost_d = loss ? 1'b1 : (i_clr_lost ? 1'b0 : lost_q);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= WAIT;
      cnt_q   <= '0;
      sc_q    <= '0;
      rst_q   <= '0;
      ready_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sc_q    <= sc_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      lost_q  <= lost_d;
    end
  end

`ifdef CLK_RST_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt_q;

  // Saturating count of lock-loss events; unaffected by i_clr_lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      loss_cnt_q <= '0;
    end else if (loss && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end

  assign o_loss_cnt = loss_cnt_q;
`else
  // Lock-loss counter not built.
`endif

  // Per-channel dividers; enables are masked with the next reset value so they never lead o_rst_n.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_en_div #(
      .DIV_W       (DIV_W),
      .DIV_DEFAULT (DIV_DEFAULT)
    ) u_div (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_div     (i_div[g*DIV_W +: DIV_W]),
      .i_load    (i_div_load),
      .i_en_mask (rst_d[g]),
      .o_clk_en  (o_clk_en[g])
    );
  end

  assign o_rst_n     = rst_q;
  assign o_ready     = ready_q;
  assign o_lock_lost = lost_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Self-checking bench for clk_rst_seq: directed sequences, a divider table
// and randomised lock/load traffic against a cycle-level reference model.
module tb_clk_rst_seq;

  localparam int NUM_CH   = 4;
  localparam int DIV_W    = 8;
  localparam int LOCK_CNT = 16;
  localparam int STAG     = 4;
  localparam int SYNC     = 2;
  localparam int REL_N    = LOCK_CNT + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        locked = 1'b0;
  logic        load = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] div = '0;
  logic [3:0]  o_rst_n;
  logic [3:0]  o_clk_en;
  logic        o_ready;
  logic        o_lock_lost;
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
  logic [7:0]  o_loss_cnt;
`endif

  always #5 clk = ~clk;

  clk_rst_seq #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .DIV_DEFAULT (0),
    .LOCK_CNT    (LOCK_CNT),
    .RST_STAGGER (STAG),
    .SYNC_STAGES (SYNC)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_locked    (locked),
    .i_div       (div),
    .i_div_load  (load),
    .i_clr_lost  (clr),
    .o_rst_n     (o_rst_n),
    .o_clk_en    (o_clk_en),
    .o_ready     (o_ready),
    .o_lock_lost (o_lock_lost)
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
    ,
    .o_loss_cnt  (o_loss_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: lk is i_locked seen two edges late; n counts consecutive
  // locked samples since the last restart; every output follows from n.
  int   m_e, m_n, m_losscnt;
  logic m_h0, m_h1, m_lost;
  int   m_anchor[NUM_CH];
  int   m_d[NUM_CH];
  logic [3:0] exp_rst, exp_en;
  logic exp_ready;

  int rise[NUM_CH];
  int rise_rdy;
  int gap[NUM_CH];

  typedef struct {
    logic [31:0] div;
    logic [31:0] per;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @tick %0d: actual %0h required %0h", nm, m_e, act, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_lost = 1'b0; m_h0 = 1'b0; m_h1 = 1'b0; m_losscnt = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      m_anchor[k] = m_e;
      m_d[k] = 0;
    end
  endtask

  task automatic model_step(input logic li, input logic ld, input logic cl, input logic [31:0] dv);
    logic fl, lossv;
    fl = m_h1; m_h1 = m_h0; m_h0 = li;
    m_e++;
    lossv = !fl && (m_n >= REL_N);
    m_n = fl ? ((m_n < 100000) ? m_n + 1 : m_n) : 0;
    if (lossv) m_lost = 1'b1;
    else if (cl) m_lost = 1'b0;
    if (lossv && m_losscnt < 255) m_losscnt++;
    for (int k = 0; k < NUM_CH; k++) begin
      exp_rst[k] = (m_n >= REL_N + k * STAG);
      exp_en[k]  = exp_rst[k] && (((m_e - m_anchor[k] - 1) % (m_d[k] + 1)) == 0);
      if (ld) begin
        m_anchor[k] = m_e;
        m_d[k] = int'(dv[k*8 +: 8]);
      end
    end
    exp_ready = (m_n >= REL_N + (NUM_CH - 1) * STAG + 1);
  endtask

  task automatic tick();
    logic li, ld, cl;
    logic [31:0] dv;
    li = locked; ld = load; cl = clr; dv = div;
    @(posedge clk);
    model_step(li, ld, cl, dv);
    #1;
    check("rst_n", 32'(o_rst_n), 32'(exp_rst));
    check("clk_en", 32'(o_clk_en), 32'(exp_en));
    check("ready", 32'(o_ready), 32'(exp_ready));
    check("lock_lost", 32'(o_lock_lost), 32'(m_lost));
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
    check("loss_cnt", 32'(o_loss_cnt), 32'(m_losscnt));
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0; locked = 1'b0; load = 1'b0; clr = 1'b0;
    #2;
    check("rst_val_rst_n", 32'(o_rst_n), 32'h0);
    check("rst_val_clk_en", 32'(o_clk_en), 32'h0);
    check("rst_val_ready", 32'(o_ready), 32'h0);
    check("rst_val_lost", 32'(o_lock_lost), 32'h0);
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
    check("rst_val_loss_cnt", 32'(o_loss_cnt), 32'h0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Raise lock and record on which tick each reset and ready first rise.
  task automatic measure_seq();
    for (int k = 0; k < NUM_CH; k++) rise[k] = -1;
    rise_rdy = -1;
    locked = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      for (int k = 0; k < NUM_CH; k++)
        if (o_rst_n[k] && rise[k] < 0) rise[k] = t;
      if (o_ready && rise_rdy < 0) rise_rdy = t;
    end
  endtask

  task automatic check_seq(input string tag);
    for (int k = 0; k < NUM_CH; k++)
      check($sformatf("%s_rise_ch%0d", tag, k), 32'(rise[k]), 32'(19 + 4 * k));
    check($sformatf("%s_rise_ready", tag), 32'(rise_rdy), 32'd32);
  endtask

  // Distance between the first two enable pulses of each channel.
  task automatic measure_gaps();
    int first[NUM_CH];
    int second[NUM_CH];
    for (int k = 0; k < NUM_CH; k++) begin
      first[k] = -1; second[k] = -1;
    end
    for (int t = 1; t <= 40; t++) begin
      tick();
      for (int k = 0; k < NUM_CH; k++)
        if (o_clk_en[k]) begin
          if (first[k] < 0) first[k] = t;
          else if (second[k] < 0) second[k] = t;
        end
    end
    for (int k = 0; k < NUM_CH; k++) gap[k] = second[k] - first[k];
  endtask

  initial begin
    int drop_left;
    logic [31:0] rdiv;

    vecs[0] = '{div: 32'h03020100, per: 32'h04030201};
    vecs[1] = '{div: 32'h00000000, per: 32'h01010101};
    vecs[2] = '{div: 32'h02010507, per: 32'h03020608};
    vecs[3] = '{div: 32'h0603000A, per: 32'h0704010B};

    m_e = 0;
    model_reset();
    do_reset();

    // Lock from cycle 0: staggered release timing.
    measure_seq();
    check_seq("seq1");

    // One-cycle lock glitch during qualification restarts the count, no flag.
    do_reset();
    for (int k = 0; k < NUM_CH; k++) rise[k] = -1;
    for (int t = 1; t <= 50; t++) begin
      locked = (t == 12) ? 1'b0 : 1'b1;
      tick();
      if (o_rst_n[0] && rise[0] < 0) rise[0] = t;
    end
    check("glitch_rise_ch0", 32'(rise[0]), 32'd31);
    check("glitch_no_lost", 32'(o_lock_lost), 32'd0);

    // Divider table: aligned pulse after load, then per-channel periods.
    for (int i = 0; i < 4; i++) begin
      div = vecs[i].div;
      load = 1'b1;
      tick();
      load = 1'b0;
      tick();
      check($sformatf("align_v%0d", i), 32'(o_clk_en), 32'hF);
      measure_gaps();
      for (int k = 0; k < NUM_CH; k++)
        check($sformatf("period_v%0d_ch%0d", i, k), 32'(gap[k]), 32'(vecs[i].per[k*8 +: 8]));
    end

    // Lock loss in RUN, re-sequence, then clear the sticky flag.
    locked = 1'b0;
    tick();
    tick();
    check("loss_ready_hold", 32'(o_ready), 32'd1);
    tick();
    check("loss_rst_n", 32'(o_rst_n), 32'h0);
    check("loss_ready", 32'(o_ready), 32'd0);
    check("loss_flag", 32'(o_lock_lost), 32'd1);
    repeat (3) tick();
    measure_seq();
    check_seq("relock");
    check("lost_sticky", 32'(o_lock_lost), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("lost_cleared", 32'(o_lock_lost), 32'd0);

    // Divide load coincident with lock loss.
    locked = 1'b0;
    tick();
    tick();
    div = 32'h05020401;
    load = 1'b1;
    tick();
    load = 1'b0;
    check("loadloss_rst_n", 32'(o_rst_n), 32'h0);
    check("loadloss_flag", 32'(o_lock_lost), 32'd1);
    repeat (2) tick();
    measure_seq();
    check_seq("loadloss");
    measure_gaps();
    check("loadloss_per_ch0", 32'(gap[0]), 32'd2);
    check("loadloss_per_ch1", 32'(gap[1]), 32'd5);
    check("loadloss_per_ch2", 32'(gap[2]), 32'd3);
    check("loadloss_per_ch3", 32'(gap[3]), 32'd6);

    // Random lock drops, loads and clears against the model, with one async reset.
    drop_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      if (drop_left > 0) begin
        locked = 1'b0;
        drop_left--;
      end else begin
        locked = 1'b1;
        if ($urandom_range(0, 149) == 0) drop_left = int'($urandom_range(1, 4));
      end
      load = ($urandom_range(0, 24) == 0);
      for (int k = 0; k < NUM_CH; k++) rdiv[k*8 +: 8] = 8'($urandom_range(0, 6));
      div = rdiv;
      clr = ($urandom_range(0, 39) == 0);
      tick();
    end
    load = 1'b0;
    clr = 1'b0;

`ifdef CLK_RST_SEQ_LOSS_CNT_EN
    // Loss counter saturates and is cleared only by reset.
    for (int i = 0; i < 300; i++) begin
      locked = 1'b1;
      repeat (20) tick();
      locked = 1'b0;
      repeat (3) tick();
    end
    check("loss_cnt_sat", 32'(o_loss_cnt), 32'd255);
    do_reset();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
